// File: rtl/eth_measurer_responder.sv
// eth_measurer_responder
//
// Standalone pong responder. It watches one TEMAC RX byte stream for ping
// frames addressed to this interface and answers each one on the same TEMAC's
// TX stream. The pong echoes the ping's ping_id and has the same length,
// capped at 1514 bytes, so the remote measurer sees a symmetric round trip.
//
// Frame layout (byte index, all fields big-endian / MSB first):
//   0-5 dst MAC, 6-11 src MAC, 12-13 ethertype, 14-17 identifier,
//   18-25 ping_id, 26.. padding.
//
// Ports
//   clk, rst_n           single clock, asynchronous active-low reset
//   enable               1: answer pings, 0: discard RX frames (sampled at byte 0)
//   s_axis_*             RX byte stream from TEMAC, no backpressure
//   m_axis_*             TX byte stream to TEMAC
//   pongs_sent           pongs fully transmitted (wraps)
//   pings_dropped        valid pings discarded because TX was busy (wraps)
//
// TX handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high. Once tvalid is raised it stays high, and
// tdata/tlast hold their value, until that beat transfers.

module eth_measurer_responder #(
    parameter logic [47:0] local_mac  = 48'h02_00_00_00_00_02,
    parameter logic [31:0] identifier = 32'h5A424E54,
    parameter logic [15:0] ethertype  = 16'h88B5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] pongs_sent,
    output logic [31:0] pings_dropped
);

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_PAD  = 2'd1,
        RX_DROP = 2'd2
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    localparam logic [10:0] max_pong_len = 11'd1514;

    // Reference header for RX comparison; the src MAC and ping_id slots are
    // don't-care and are masked out by rx_must_match.
    localparam logic [207:0] rx_ref_hdr = {local_mac, 48'h0, ethertype, identifier, 64'h0};

    // Byte idx (0..25) of a 26-byte header vector, MSB byte first.
    function automatic logic [7:0] hdr_byte(input logic [207:0] hdr, input logic [4:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 26; b++) begin
            if (idx == b[4:0]) begin
                r = hdr[8*(25-b) +: 8];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_len_q, rx_len_d;
    logic [47:0] rx_peer_q, rx_peer_d;
    logic [63:0] rx_id_q, rx_id_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [10:0] tx_idx_q, tx_idx_d;
    logic [10:0] tx_len_q, tx_len_d;
    logic [47:0] tx_peer_q, tx_peer_d;
    logic [63:0] tx_id_q, tx_id_d;

    logic [31:0] pongs_sent_q, pongs_sent_d;
    logic [31:0] pings_dropped_q, pings_dropped_d;

    // ------------------------------------------------------------------
    // RX parser
    // ------------------------------------------------------------------
    logic        rx_beat;
    logic [15:0] rx_len_inc;
    logic        rx_must_match;
    logic        rx_byte_ok;
    logic        ping_valid;
    logic [10:0] ping_pong_len;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_len_d      = rx_len_q;
        rx_peer_d     = rx_peer_q;
        rx_id_d       = rx_id_q;
        ping_valid    = 1'b0;

        rx_beat       = s_axis_tvalid & s_axis_tkeep;
        rx_len_inc    = (rx_len_q == 16'hFFFF) ? rx_len_q : rx_len_q + 16'd1;
        rx_must_match = (rx_len_q < 16'd6) ||
                        ((rx_len_q >= 16'd12) && (rx_len_q < 16'd18));
        rx_byte_ok    = (s_axis_tdata == hdr_byte(rx_ref_hdr, rx_len_q[4:0]));
        // rx_len_inc already includes the current (tlast) byte.
        ping_pong_len = (rx_len_inc > 16'd1514) ? max_pong_len : rx_len_inc[10:0];

        if (rx_beat) begin
            rx_len_d = s_axis_tlast ? 16'd0 : rx_len_inc;
            unique case (rx_state_q)
                RX_HDR: begin
                    if ((rx_len_q >= 16'd6) && (rx_len_q < 16'd12)) begin
                        rx_peer_d = {rx_peer_q[39:0], s_axis_tdata};
                    end
                    if ((rx_len_q >= 16'd18) && (rx_len_q < 16'd26)) begin
                        rx_id_d = {rx_id_q[55:0], s_axis_tdata};
                    end
                    if (s_axis_tlast) begin
                        // Frame ended inside the header: only a frame that
                        // ends exactly on byte 25 is a complete ping.
                        rx_state_d = RX_HDR;
                        ping_valid = (rx_len_q == 16'd25) && !s_axis_tuser;
                    end else if (((rx_len_q == 16'd0) && !enable) ||
                                 (rx_must_match && !rx_byte_ok)) begin
                        rx_state_d = RX_DROP;
                    end else if (rx_len_q == 16'd25) begin
                        rx_state_d = RX_PAD;
                    end
                end
                RX_PAD: begin
                    if (s_axis_tlast) begin
                        rx_state_d = RX_HDR;
                        ping_valid = !s_axis_tuser;
                    end
                end
                RX_DROP: begin
                    if (s_axis_tlast) begin
                        rx_state_d = RX_HDR;
                    end
                end
                default: begin
                    rx_state_d = RX_HDR;
                    rx_len_d   = 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX generator
    // ------------------------------------------------------------------
    logic         tx_fire;
    logic         tx_at_last;
    logic         tx_final_hs;
    logic         tx_can_latch;
    logic [207:0] tx_hdr;

    always_comb begin
        tx_state_d      = tx_state_q;
        tx_idx_d        = tx_idx_q;
        tx_len_d        = tx_len_q;
        tx_peer_d       = tx_peer_q;
        tx_id_d         = tx_id_q;
        pongs_sent_d    = pongs_sent_q;
        pings_dropped_d = pings_dropped_q;

        tx_fire      = (tx_state_q == TX_SEND) && m_axis_tready;
        tx_at_last   = (tx_idx_q == (tx_len_q - 11'd1));
        tx_final_hs  = tx_fire && tx_at_last;
        // A new ping can be accepted when idle or when the current pong's
        // last byte leaves this very cycle (back-to-back, no idle gap).
        tx_can_latch = (tx_state_q == TX_IDLE) || tx_final_hs;

        if (tx_fire) begin
            if (tx_at_last) begin
                pongs_sent_d = pongs_sent_q + 32'd1;
                tx_state_d   = TX_IDLE;
                tx_idx_d     = 11'd0;
            end else begin
                tx_idx_d = tx_idx_q + 11'd1;
            end
        end

        if (ping_valid) begin
            if (tx_can_latch) begin
                tx_state_d = TX_SEND;
                tx_idx_d   = 11'd0;
                tx_len_d   = ping_pong_len;
                tx_peer_d  = rx_peer_d;
                tx_id_d    = rx_id_d;
            end else begin
                pings_dropped_d = pings_dropped_q + 32'd1;
            end
        end
    end

    assign tx_hdr = {tx_peer_q, local_mac, ethertype, identifier, tx_id_q};

    always_comb begin
        m_axis_tvalid = (tx_state_q == TX_SEND);
        m_axis_tkeep  = m_axis_tvalid;
        m_axis_tlast  = m_axis_tvalid && tx_at_last;
        m_axis_tdata  = 8'h00;
        if (m_axis_tvalid && (tx_idx_q < 11'd26)) begin
            m_axis_tdata = hdr_byte(tx_hdr, tx_idx_q[4:0]);
        end
    end

    assign pongs_sent    = pongs_sent_q;
    assign pings_dropped = pings_dropped_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q      <= RX_HDR;
            rx_len_q        <= 16'd0;
            rx_peer_q       <= 48'd0;
            rx_id_q         <= 64'd0;
            tx_state_q      <= TX_IDLE;
            tx_idx_q        <= 11'd0;
            tx_len_q        <= 11'd0;
            tx_peer_q       <= 48'd0;
            tx_id_q         <= 64'd0;
            pongs_sent_q    <= 32'd0;
            pings_dropped_q <= 32'd0;
        end else begin
            rx_state_q      <= rx_state_d;
            rx_len_q        <= rx_len_d;
            rx_peer_q       <= rx_peer_d;
            rx_id_q         <= rx_id_d;
            tx_state_q      <= tx_state_d;
            tx_idx_q        <= tx_idx_d;
            tx_len_q        <= tx_len_d;
            tx_peer_q       <= tx_peer_d;
            tx_id_q         <= tx_id_d;
            pongs_sent_q    <= pongs_sent_d;
            pings_dropped_q <= pings_dropped_d;
        end
    end

endmodule

// File: tb/tb_eth_measurer_responder.sv
module tb_eth_measurer_responder;

  localparam logic [47:0] local_mac_c = 48'h02_00_00_00_00_02;
  localparam logic [31:0] ident_c     = 32'h5A424E54;
  localparam logic [15:0] eth_c       = 16'h88B5;
  localparam logic [47:0] peer_a      = 48'h0A_11_22_33_44_55;
  localparam logic [47:0] peer_b      = 48'h0A_66_77_88_99_AA;
  localparam logic [63:0] id_a        = 64'h0123456789ABCDEF;
  localparam logic [63:0] id_b        = 64'hFEDCBA9876543210;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] pongs_sent;
  logic [31:0] pings_dropped;

  eth_measurer_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pongs_sent    (pongs_sent),
    .pings_dropped (pings_dropped)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];       // {tlast, tdata}
  int         exp_pongs = 0;
  int         exp_drops = 0;
  int         pong_beats = 0;
  int         ready_mode = 0; // 0: always 1, 1: toggle, 2: hold 0
  logic [7:0] frame [0:2047];
  int         frame_len = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- tready driver ----------------
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (m_axis_tvalid) begin
      checks++;
      if (m_axis_tkeep !== 1'b1) begin
        errors++;
        $display("FAIL tkeep: got %0b expected 1", m_axis_tkeep);
      end
      if (prev_stall) begin
        checks++;
        if ({m_axis_tlast, m_axis_tdata} !== {prev_last, prev_data}) begin
          errors++;
          $display("FAIL stall_hold: got %0h expected %0h", {m_axis_tlast, m_axis_tdata}, {prev_last, prev_data});
        end
      end
      if (m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            errors++;
            $display("FAIL pong_byte %0d: got %0h expected %0h", pong_beats, {m_axis_tlast, m_axis_tdata}, e);
          end
        end
        pong_beats++;
      end
      prev_stall = !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [31:0] ident, input logic [63:0] id, input int len);
    logic [207:0] hdr;
    hdr = {dst, src, eth_c, ident, id};
    for (int i = 0; i < len; i++) begin
      if (i < 26) frame[i] = hdr[8*(25-i) +: 8];
      else        frame[i] = 8'hA5 ^ i[7:0];
    end
    frame_len = len;
  endtask

  task automatic push_pong(input logic [47:0] src, input logic [63:0] id, input int len);
    logic [207:0] hdr;
    int plen;
    plen = (len > 1514) ? 1514 : len;
    hdr  = {src, local_mac_c, eth_c, ident_c, id};
    for (int i = 0; i < plen; i++) begin
      if (i < 26) exp_q.push_back({i == plen - 1, hdr[8*(25-i) +: 8]});
      else        exp_q.push_back({i == plen - 1, 8'h00});
    end
    exp_pongs++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the tlast beat was sampled.
  task automatic send_frame(input logic tuser_last);
    for (int i = 0; i < frame_len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tkeep  = 1'b1;
      s_axis_tdata  = frame[i];
      s_axis_tlast  = (i == frame_len - 1);
      s_axis_tuser  = (i == frame_len - 1) ? tuser_last : 1'b0;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = 8'h00;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n         = 1'b0;
    enable        = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b0;
    idle(3);
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset_pongs", 64'(pongs_sent), 64'd0);
    chk("reset_drops", 64'(pings_dropped), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Rejected frames: wrong identifier, wrong dst, bad FCS, disabled.
    build_frame(local_mac_c, peer_a, 32'h5A424E55, id_a, 64);
    send_frame(1'b0);
    build_frame(48'h02_00_00_00_00_03, peer_a, ident_c, id_a, 64);
    send_frame(1'b0);
    build_frame(local_mac_c, peer_a, ident_c, id_a, 64);
    send_frame(1'b1);
    enable = 1'b0;
    send_frame(1'b0);
    enable = 1'b1;
    idle(40);
    chk("reject_pongs", 64'(pongs_sent), 64'd0);
    chk("reject_drops", 64'(pings_dropped), 64'd0);

    // Basic 64-byte ping, 1-cycle latency.
    build_frame(local_mac_c, peer_a, ident_c, id_a, 64);
    push_pong(peer_a, id_a, 64);
    send_frame(1'b0);
    chk("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    drain("basic");
    chk("basic_pongs", 64'(pongs_sent), 64'(exp_pongs));

    // Truncated frame followed by a good ping.
    build_frame(local_mac_c, peer_b, ident_c, id_b, 20);
    send_frame(1'b0);
    build_frame(local_mac_c, peer_b, ident_c, id_b, 64);
    push_pong(peer_b, id_b, 64);
    send_frame(1'b0);
    drain("trunc");
    chk("trunc_pongs", 64'(pongs_sent), 64'(exp_pongs));

    // Minimum ping: tlast on byte 25.
    build_frame(local_mac_c, peer_a, ident_c, id_b, 26);
    push_pong(peer_a, id_b, 26);
    send_frame(1'b0);
    drain("min");

    // Oversize ping clipped to 1514.
    build_frame(local_mac_c, peer_b, ident_c, id_a, 2000);
    push_pong(peer_b, id_a, 2000);
    send_frame(1'b0);
    drain("big");
    chk("big_pongs", 64'(pongs_sent), 64'(exp_pongs));

    // tready toggling.
    ready_mode = 1;
    build_frame(local_mac_c, peer_a, ident_c, id_a, 64);
    push_pong(peer_a, id_a, 64);
    send_frame(1'b0);
    drain("toggle");
    ready_mode = 0;
    chk("toggle_pongs", 64'(pongs_sent), 64'(exp_pongs));

    // Back-to-back pings while TX is stalled.
    ready_mode = 2;
    idle(2);
    build_frame(local_mac_c, peer_a, ident_c, id_a, 64);
    push_pong(peer_a, id_a, 64);
    send_frame(1'b0);
    build_frame(local_mac_c, peer_b, ident_c, id_b, 64);
    send_frame(1'b0);
    exp_drops++;
    idle(20);
    chk("stall_drops", 64'(pings_dropped), 64'(exp_drops));
    chk("stall_pongs", 64'(pongs_sent), 64'(exp_pongs - 1));
    ready_mode = 0;
    drain("stall");
    chk("stall_pongs_after", 64'(pongs_sent), 64'(exp_pongs));
    chk("stall_drops_after", 64'(pings_dropped), 64'(exp_drops));

    // Reset in the middle of a pong.
    pong_beats = 0;
    build_frame(local_mac_c, peer_b, ident_c, id_b, 64);
    push_pong(peer_b, id_b, 64);
    send_frame(1'b0);
    n = 0;
    while (pong_beats < 30 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_byte30", 64'(pong_beats), 64'd30);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midreset_pongs", 64'(pongs_sent), 64'd0);
    chk("midreset_drops", 64'(pings_dropped), 64'd0);
    exp_q.delete();
    exp_pongs = 0;
    exp_drops = 0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    chk("after_reset_idle", 64'(m_axis_tvalid), 64'd0);
    build_frame(local_mac_c, peer_a, ident_c, id_a, 64);
    push_pong(peer_a, id_a, 64);
    send_frame(1'b0);
    drain("post_reset");
    chk("post_reset_pongs", 64'(pongs_sent), 64'(exp_pongs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
